// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the BRAM-to-BRAM copy controller: FSM states and
// write-enable / word-size constants.
package bram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] WE_ALL     = 4'b1111;
  localparam logic [3:0] WE_NONE    = 4'b0000;

endpackage

// File: rtl/bram_rd_pipe.sv
// Tracks in-flight source reads: a LATENCY-deep shift register carrying a
// valid bit and the destination address that the returning word belongs to.
module bram_rd_pipe #(
  parameter int LATENCY = 2,
  parameter int AW      = 15
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  output logic          o_valid,
  output logic [AW-1:0] o_addr
);

  logic [LATENCY-1:0]         r_valid;
  logic [LATENCY-1:0][AW-1:0] r_addr;

  // Flush only kills the valid bits; stale addresses are harmless without them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_addr  <= '0;
    end else begin
      r_valid[0] <= i_valid && !i_flush;
      r_addr[0]  <= i_addr;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1] && !i_flush;
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_addr  = r_addr[LATENCY-1];

endmodule

// File: rtl/bram_copy_ctrl.sv
// Copies word_count 32-bit words from a read-only source BRAM port to a
// destination BRAM port, one read per cycle, ascending addresses with wrap.
module bram_copy_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int RD_LATENCY      = 2
) (
  input  logic                       BRAM_CLK,
  input  logic                       BRAM_RSTN,
  input  logic                       start,
  input  logic                       abort,
  input  logic [BRAM_ADDR_WIDTH-1:0] src_base,
  input  logic [BRAM_ADDR_WIDTH-1:0] dst_base,
  input  logic [BRAM_ADDR_WIDTH-2:0] word_count,
  output logic                       busy,
  output logic                       done,
  output logic [BRAM_ADDR_WIDTH-1:0] SRC_ADDR,
  output logic                       SRC_EN,
  input  logic [31:0]                SRC_RDDATA,
  output logic [BRAM_ADDR_WIDTH-1:0] DST_ADDR,
  output logic [31:0]                DST_WRDATA,
  output logic                       DST_EN,
  output logic [3:0]                 DST_WE
);

  localparam int                        AW       = BRAM_ADDR_WIDTH;
  localparam int                        CW       = BRAM_ADDR_WIDTH - 1;
  localparam logic [CW-1:0]             CNT_ONE  = CW'(1);
  localparam logic [AW-1:0]             ADDR_STEP = AW'(WORD_BYTES);
  localparam logic [AW-1:0]             ALIGN_MASK = ~AW'(WORD_BYTES - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_src_addr;
  logic [AW-1:0] r_dst_addr;
  logic [CW-1:0] r_rd_rem;
  logic [CW-1:0] r_wr_rem;
  logic [AW-1:0] r_dst_hold;
  logic [31:0]   r_data_hold;

  logic          w_start_ok;
  logic          w_issue;
  logic          w_pipe_valid;
  logic [AW-1:0] w_pipe_addr;
  logic          w_wr_fire;

  assign w_start_ok = (r_state == IDLE) && start && !abort;
  assign w_issue    = (r_state == READ) && !abort;
  assign w_wr_fire  = w_pipe_valid && !abort;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_state_next = (word_count != '0) ? READ : FINISH;
        end
      end
      READ: begin
        if (abort) begin
          w_state_next = IDLE;
        end else if (r_rd_rem == CNT_ONE) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The final write can only surface here, never while reads are still issuing.
        if (abort) begin
          w_state_next = IDLE;
        end else if (w_wr_fire && (r_wr_rem == CNT_ONE)) begin
          w_state_next = FINISH;
        end
      end
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge BRAM_CLK or negedge BRAM_RSTN) begin
    if (!BRAM_RSTN) begin
      r_state     <= IDLE;
      r_src_addr  <= '0;
      r_dst_addr  <= '0;
      r_rd_rem    <= '0;
      r_wr_rem    <= '0;
      r_dst_hold  <= '0;
      r_data_hold <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_ok) begin
        r_src_addr <= src_base & ALIGN_MASK;
        r_dst_addr <= dst_base & ALIGN_MASK;
        r_rd_rem   <= word_count;
        r_wr_rem   <= word_count;
      end
      if (w_issue) begin
        r_rd_rem   <= r_rd_rem - CNT_ONE;
        r_dst_addr <= r_dst_addr + ADDR_STEP;
        // Keep SRC_ADDR on the last issued address once reads stop.
        if (r_rd_rem != CNT_ONE) begin
          r_src_addr <= r_src_addr + ADDR_STEP;
        end
      end
      if (w_wr_fire) begin
        r_wr_rem    <= r_wr_rem - CNT_ONE;
        r_dst_hold  <= w_pipe_addr;
        r_data_hold <= SRC_RDDATA;
      end
    end
  end

  bram_rd_pipe #(
    .LATENCY (RD_LATENCY),
    .AW      (AW)
  ) u_rd_pipe (
    .i_clk   (BRAM_CLK),
    .i_rst_n (BRAM_RSTN),
    .i_flush (abort),
    .i_valid (w_issue),
    .i_addr  (r_dst_addr),
    .o_valid (w_pipe_valid),
    .o_addr  (w_pipe_addr)
  );

  assign busy       = (r_state == READ) || (r_state == DRAIN);
  assign done       = (r_state == FINISH);
  assign SRC_EN     = w_issue;
  assign SRC_ADDR   = r_src_addr;
  assign DST_EN     = w_wr_fire;
  assign DST_WE     = w_wr_fire ? WE_ALL : WE_NONE;
  assign DST_ADDR   = w_wr_fire ? w_pipe_addr : r_dst_hold;
  assign DST_WRDATA = w_wr_fire ? SRC_RDDATA : r_data_hold;

endmodule

// File: tb/tb_bram_copy_ctrl.sv
// Bench for bram_copy_ctrl: behavioural source/destination BRAMs, a
// transaction-level reference model and directed plus randomized copies.
module tb_bram_copy_ctrl;

  localparam int AW    = 15;
  localparam int L     = 2;
  localparam int WORDS = 8192;

  logic          BRAM_CLK   = 1'b0;
  logic          BRAM_RSTN  = 1'b0;
  logic          start      = 1'b0;
  logic          abort      = 1'b0;
  logic [AW-1:0] src_base   = '0;
  logic [AW-1:0] dst_base   = '0;
  logic [AW-2:0] word_count = '0;
  logic          busy, done, SRC_EN, DST_EN;
  logic [AW-1:0] SRC_ADDR, DST_ADDR;
  logic [31:0]   SRC_RDDATA, DST_WRDATA;
  logic [3:0]    DST_WE;

  bram_copy_ctrl #(.BRAM_ADDR_WIDTH(AW), .RD_LATENCY(L)) dut (
    .BRAM_CLK   (BRAM_CLK),
    .BRAM_RSTN  (BRAM_RSTN),
    .start      (start),
    .abort      (abort),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .SRC_ADDR   (SRC_ADDR),
    .SRC_EN     (SRC_EN),
    .SRC_RDDATA (SRC_RDDATA),
    .DST_ADDR   (DST_ADDR),
    .DST_WRDATA (DST_WRDATA),
    .DST_EN     (DST_EN),
    .DST_WE     (DST_WE)
  );

  always #5 BRAM_CLK = ~BRAM_CLK;

  int tcyc = 0;
  always @(posedge BRAM_CLK) tcyc <= tcyc + 1;

  // Behavioural BRAMs: source has a two-cycle registered read path.
  logic [31:0] src_mem [WORDS];
  logic [31:0] dst_mem [WORDS];
  logic [31:0] rd_p1 = '0, rd_p2 = '0;
  always @(posedge BRAM_CLK) begin
    if (SRC_EN) rd_p1 <= src_mem[SRC_ADDR[AW-1:2]];
    rd_p2 <= rd_p1;
    if (DST_EN && DST_WE == 4'hF) dst_mem[DST_ADDR[AW-1:2]] <= DST_WRDATA;
  end
  assign SRC_RDDATA = rd_p2;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          base_cyc = 0;
  logic        logging  = 1'b0;
  logic [63:0] rd_log[$];
  logic [63:0] wr_log[$];
  int          done_log[$];
  int          busy_cnt, busy_last, we_viol, mon_rel;

  always @(negedge BRAM_CLK) begin
    if (logging) begin
      mon_rel = tcyc - base_cyc;
      if (SRC_EN) rd_log.push_back({32'(mon_rel), 17'd0, SRC_ADDR});
      if (DST_EN) wr_log.push_back({16'(mon_rel), 1'b0, DST_ADDR, DST_WRDATA});
      if (done) done_log.push_back(mon_rel);
      if (busy) begin
        busy_cnt++;
        busy_last = mon_rel;
      end
      if ((DST_EN && DST_WE != 4'hF) || (!DST_EN && DST_WE != 4'h0)) we_viol++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     64'(busy),     64'd0);
    check({tag, "_done"},     64'(done),     64'd0);
    check({tag, "_src_en"},   64'(SRC_EN),   64'd0);
    check({tag, "_dst_en"},   64'(DST_EN),   64'd0);
    check({tag, "_dst_we"},   64'(DST_WE),   64'd0);
    check({tag, "_src_addr"}, 64'(SRC_ADDR), 64'd0);
    check({tag, "_dst_addr"}, 64'(DST_ADDR), 64'd0);
  endtask

  // One copy request; abort_at / rst_at / restart_at are cycles relative to
  // the start cycle (cycle 0), or -1 for none.
  task automatic run_xfer(input string tag, input logic [AW-1:0] sb, input logic [AW-1:0] db,
                          input int n, input int abort_at, input int rst_at, input int restart_at);
    logic [63:0] exp_rd[$];
    logic [63:0] exp_wr[$];
    int          exp_done[$];
    int          sb_al, db_al, cut, exp_busy, sa, rc, wc;

    sb_al = int'(sb) & ~3;
    db_al = int'(db) & ~3;
    cut   = (abort_at >= 0) ? abort_at : rst_at;
    for (int k = 0; k < n; k++) begin
      rc = 1 + k;
      wc = 1 + L + k;
      sa = (sb_al + 4 * k) % 32768;
      if (cut < 0 || rc < cut) exp_rd.push_back({32'(rc), 17'd0, 15'(sa)});
      if (cut < 0 || wc < cut)
        exp_wr.push_back({16'(wc), 1'b0, 15'((db_al + 4 * k) % 32768), src_mem[sa / 4]});
    end
    if (cut < 0) exp_done.push_back((n == 0) ? 1 : n + L + 1);
    if (n == 0)          exp_busy = 0;
    else if (cut < 0)    exp_busy = n + L;
    else if (abort_at >= 0) exp_busy = cut;
    else                 exp_busy = cut - 1;

    rd_log.delete();
    wr_log.delete();
    done_log.delete();
    busy_cnt = 0;
    busy_last = -1;
    we_viol = 0;

    @(posedge BRAM_CLK); #1;
    src_base   = sb;
    dst_base   = db;
    word_count = (AW-1)'(n);
    start      = 1'b1;
    abort      = (abort_at == 0);
    base_cyc   = tcyc;
    logging    = 1'b1;
    for (int rel = 1; rel <= n + L + 6; rel++) begin
      @(posedge BRAM_CLK); #1;
      start = (rel == restart_at);
      if (start) begin
        src_base   = AW'($urandom);
        word_count = (AW-1)'(5);
      end
      abort = (rel == abort_at);
      if (rel == rst_at) begin
        BRAM_RSTN = 1'b0;
        #2;
        check_reset_outputs({tag, "_rstmid"});
      end
      if (rst_at > 0 && rel == rst_at + 2) BRAM_RSTN = 1'b1;
    end
    logging = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;

    check({tag, "_we_viol"}, 64'(we_viol), 64'd0);
    check({tag, "_nrd"}, 64'(rd_log.size()), 64'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), (i < rd_log.size()) ? rd_log[i] : '1, exp_rd[i]);
    check({tag, "_nwr"}, 64'(wr_log.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), (i < wr_log.size()) ? wr_log[i] : '1, exp_wr[i]);
    check({tag, "_ndone"}, 64'(done_log.size()), 64'(exp_done.size()));
    for (int i = 0; i < exp_done.size(); i++)
      check($sformatf("%s_done%0d", tag, i), (i < done_log.size()) ? 64'(done_log[i]) : '1,
            64'(exp_done[i]));
    check({tag, "_busy_cnt"}, 64'(busy_cnt), 64'(exp_busy));
    if (exp_busy > 0) check({tag, "_busy_last"}, 64'(busy_last), 64'(exp_busy));

    $display("xfer %s src=%h dst=%h n=%0d reads=%0d writes=%0d dones=%0d busy=%0d",
             tag, sb, db, n, rd_log.size(), wr_log.size(), done_log.size(), busy_cnt);
  endtask

  initial begin
    int n, ab, mism;

    for (int i = 0; i < WORDS; i++) src_mem[i] = 32'(i);

    #3;
    check_reset_outputs("por");
    @(posedge BRAM_CLK); #1;
    BRAM_RSTN = 1'b1;
    repeat (2) @(posedge BRAM_CLK);

    run_xfer("full", 15'h0000, 15'h0000, 8192, -1, -1, -1);
    mism = 0;
    for (int i = 0; i < WORDS; i++) if (dst_mem[i] !== 32'(i)) mism++;
    check("full_dst_words", 64'(mism), 64'd0);

    run_xfer("wrap", 15'h7FF8, 15'h0100, 4, -1, -1, -1);
    run_xfer("zero", 15'h0040, 15'h0080, 0, -1, -1, -1);
    run_xfer("abort6", 15'h0000, 15'h2000, 16, 6, -1, -1);
    run_xfer("after_abort", 15'h0123, 15'h3000, 8, -1, -1, -1);
    run_xfer("abort_start", 15'h0010, 15'h0020, 5, 0, -1, -1);
    run_xfer("rst5", 15'h0200, 15'h4000, 16, -1, 5, -1);
    run_xfer("restart_busy", 15'h0300, 15'h5000, 10, -1, -1, 4);
    run_xfer("restart_fin", 15'h0400, 15'h6000, 3, -1, -1, 6);

    for (int i = 0; i < WORDS; i++) src_mem[i] = $urandom;
    for (int t = 0; t < 8; t++) begin
      n  = $urandom_range(1, 40);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + L) : -1;
      run_xfer($sformatf("rand%0d", t), AW'($urandom), AW'($urandom), n, ab, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
